// File: rtl/mul_seq_pkg.sv
// mul_pkg: shared types and elaboration helpers for the mul_seq multiplier.
//   mul_state_t : controller states (IDLE, RUN)
//   calc_n      : iterations per multiply, WIDTH/DIGIT
//   calc_cnt_w  : iteration counter width, $clog2(N+1)
package mul_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_t;

  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int calc_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: start/done handshake and operand/product bus of mul_seq.
//   start : request a multiply (sampled while ready=1)
//   a, b  : multiplicand / multiplier, WIDTH bits
//   sgn   : signed-mode select (only with MUL_SEQ_SIGNED_EN)
//   ready : multiplier idle, accepts start
//   done  : one-cycle completion pulse
//   p     : 2*WIDTH-bit product
// Modports: master (requester side), slave (multiplier side).
interface mul_seq_if #(
  parameter int WIDTH = 1024
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef MUL_SEQ_SIGNED_EN
  logic                 sgn;
`endif
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

`ifdef MUL_SEQ_SIGNED_EN
  modport master (output start, a, b, sgn, input ready, done, p);
  modport slave  (input start, a, b, sgn, output ready, done, p);
`else
  modport master (output start, a, b, input ready, done, p);
  modport slave  (input start, a, b, output ready, done, p);
`endif

endinterface

// File: rtl/mul_seq_pe.sv
// mul_seq_pe: combinational digit step of the iterative multiplier.
// Adds a x digit into the upper WIDTH+DIGIT accumulator slice.
//   a      : multiplicand, WIDTH bits
//   digit  : current DIGIT-bit slice of the multiplier
//   acc_hi : accumulator upper slice, WIDTH+DIGIT bits
//   sum    : acc_hi + a*digit, WIDTH+DIGIT bits
// The entering slice is always below 2^WIDTH (its top DIGIT bits were
// shifted in as zero), so the sum never exceeds WIDTH+DIGIT bits.
module mul_seq_pe
  import mul_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int DIGIT = 32
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       digit,
  input  logic [WIDTH+DIGIT-1:0] acc_hi,
  output logic [WIDTH+DIGIT-1:0] sum
);

  always_comb begin
    sum = acc_hi + ({{DIGIT{1'b0}}, a} * {{WIDTH{1'b0}}, digit});
  end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative WIDTH x WIDTH multiplier, DIGIT multiplier bits per
// clock, N = WIDTH/DIGIT iterations, product registered on the done edge.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any multiply in flight
//   bus : mul_seq_if.slave (start/a/b[/sgn] in, ready/done/p out)
// Optional feature macro: MUL_SEQ_SIGNED_EN adds two's-complement mode
// selected by sgn (sign-magnitude at capture, negate at the final edge).
//
// state | meaning
// IDLE  | ready=1, waiting for start; captures operands on accept
// RUN   | ready=0, one DIGIT-bit step per clock for N clocks
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int DIGIT = 32
) (
  input  logic     clk,
  input  logic     rst,
  mul_seq_if.slave bus
);

  localparam int N     = calc_n(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(N);
  localparam int ACC_W = 2 * WIDTH + DIGIT;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("mul_seq: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  logic [0:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [ACC_W-1:0]     acc;
  logic [2*WIDTH-1:0]   p_r;
  logic                 done_r;

  logic [WIDTH+DIGIT-1:0] pe_sum;
  logic [ACC_W-1:0]       acc_next;
  logic [2*WIDTH-1:0]     result;
  logic                   last;
  logic [WIDTH-1:0]       a_cap;
  logic [WIDTH-1:0]       b_cap;

  mul_seq_pe #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_pe (
    .a      (a_r),
    .digit  (b_r[DIGIT-1:0]),
    .acc_hi (acc[ACC_W-1:WIDTH]),
    .sum    (pe_sum)
  );

  always_comb begin
    acc_next = {pe_sum, acc[WIDTH-1:0]} >> DIGIT;
    last     = (cnt == CNT_W'(N - 1));
  end

`ifdef MUL_SEQ_SIGNED_EN
  logic neg_r;
  logic neg_cap;

  // Operands are held as magnitudes; the product sign is restored at the end.
  always_comb begin
    a_cap   = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_cap   = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    neg_cap = bus.sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    result  = neg_r ? -acc_next[2*WIDTH-1:0] : acc_next[2*WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_r <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      neg_r <= neg_cap;
    end
  end
`else
  always_comb begin
    a_cap  = bus.a;
    b_cap  = bus.b;
    result = acc_next[2*WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      p_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_r   <= a_cap;
            b_r   <= b_cap;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          b_r <= b_r >> DIGIT;
          cnt <= cnt + 1'b1;
          if (last) begin
            p_r    <= result;
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.done  = done_r;
  assign bus.p     = p_r;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  localparam int WIDTH = 1024;
  localparam int DIGIT = 32;
  localparam int N     = WIDTH / DIGIT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(WIDTH)) bus ();

  mul_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference: integer product modulo 2^(2*WIDTH), signed via sign extension.
  function automatic logic [2*WIDTH-1:0] ref_product(input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y,
                                                      input logic s);
    logic [2*WIDTH-1:0] xe, ye;
    xe = s ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ye = s ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    return xe * ye;
  endfunction

  task automatic set_sgn(input logic s);
`ifdef MUL_SEQ_SIGNED_EN
    bus.sgn = s;
`else
    if (s) $display("note: sgn ignored in unsigned build");
`endif
  endtask

  // Called on a negedge: presents a one-cycle start, returns on the negedge
  // after the accepting edge with operands scrambled.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    set_sgn(s);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = rand_wide();
    bus.b     = rand_wide();
    set_sgn(~s);
  endtask

  // Counts edges after acceptance until done; lat=-1 on timeout.
  task automatic wait_done(output int lat, output bit ready_bad);
    lat       = -1;
    ready_bad = 1'b0;
    for (int k = 0; k <= N + 4; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.ready !== 1'b0) ready_bad = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic count_done(input int cycles, output int n_done, output bit p_changed);
    logic [2*WIDTH-1:0] p0;
    p0        = bus.p;
    n_done    = 0;
    p_changed = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      if (bus.p !== p0) p_changed = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.p !== '0) begin errors++; $display("FAIL reset_p got=%0h want=0", bus.p); end
  endtask

  task automatic test_basic();
    int lat; bit rbad; int nd; bit pc;
    issue(WIDTH'(3423), WIDTH'(434), 1'b0);
    wait_done(lat, rbad);
    checks++; if (lat !== N) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, N); end
    checks++; if (rbad !== 1'b0) begin errors++; $display("FAIL basic_ready_low got=%b want=0", rbad); end
    checks++; if (bus.p !== (2*WIDTH)'(1485582)) begin errors++; $display("FAIL basic_p got=%0d want=1485582", bus.p); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL basic_ready_at_done got=%b want=1", bus.ready); end
    count_done(4, nd, pc);
    checks++; if (nd !== 0) begin errors++; $display("FAIL basic_single_done got=%0d extra want=0", nd); end
    checks++; if (pc !== 1'b0) begin errors++; $display("FAIL basic_p_held got=%b want=0", pc); end
  endtask

  task automatic test_max();
    int lat; bit rbad;
    logic [2*WIDTH-1:0] e, one;
    one = 1;
    e   = '0 - (one << (WIDTH + 1)) + one;
    issue('1, '1, 1'b0);
    wait_done(lat, rbad);
    checks++; if (lat !== N) begin errors++; $display("FAIL max_latency got=%0d want=%0d", lat, N); end
    checks++; if (bus.p !== e) begin errors++; $display("FAIL max_p got=%0h want=%0h", bus.p, e); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat; bit rbad; int nd; bit pc;
    issue('0, WIDTH'(434), 1'b0);
    wait_done(lat, rbad);
    checks++; if (lat !== N) begin errors++; $display("FAIL zero_latency got=%0d want=%0d", lat, N); end
    checks++; if (bus.p !== '0) begin errors++; $display("FAIL zero_p got=%0h want=0", bus.p); end
    count_done(2 * N, nd, pc);
    checks++; if (nd !== 0) begin errors++; $display("FAIL zero_single_done got=%0d extra want=0", nd); end
  endtask

  task automatic test_busy_start();
    int lat; int nd; bit pc;
    issue(WIDTH'(3423), WIDTH'(434), 1'b0);
    lat = -1;
    for (int k = 0; k <= N + 4; k++) begin
      if (bus.done === 1'b1) begin lat = k; break; end
      bus.start = (k == 3);
      if (k == 3) begin bus.a = WIDTH'(5); bus.b = WIDTH'(7); end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++; if (lat !== N) begin errors++; $display("FAIL busy_latency got=%0d want=%0d", lat, N); end
    checks++; if (bus.p !== (2*WIDTH)'(1485582)) begin errors++; $display("FAIL busy_p got=%0d want=1485582", bus.p); end
    count_done(2 * N + 4, nd, pc);
    checks++; if (nd !== 0) begin errors++; $display("FAIL busy_no_second_done got=%0d want=0", nd); end
    checks++; if (pc !== 1'b0) begin errors++; $display("FAIL busy_p_stable got=%b want=0", pc); end
  endtask

  task automatic test_mid_reset();
    int lat; bit rbad;
    issue(WIDTH'(3423), WIDTH'(434), 1'b0);
    repeat (N / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", bus.done); end
    checks++; if (bus.p !== '0) begin errors++; $display("FAIL midrst_p got=%0h want=0", bus.p); end
    issue(WIDTH'(5), WIDTH'(7), 1'b0);
    wait_done(lat, rbad);
    checks++; if (lat !== N) begin errors++; $display("FAIL midrst_latency got=%0d want=%0d", lat, N); end
    checks++; if (bus.p !== (2*WIDTH)'(35)) begin errors++; $display("FAIL midrst_p35 got=%0d want=35", bus.p); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat; bit rbad;
    logic [WIDTH-1:0] x, y;
    logic [2*WIDTH-1:0] e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin x = '1; y = WIDTH'(1); end
        1: begin x = '0; x[WIDTH-1] = 1'b1; y = WIDTH'(2); end
        default: begin x = rand_wide(); y = rand_wide(); end
      endcase
      if (i == 2) y[WIDTH-1 -: 64] = '0;
      e = ref_product(x, y, 1'b0);
      issue(x, y, 1'b0);
      wait_done(lat, rbad);
      checks++; if (lat !== N || rbad !== 1'b0) begin errors++; $display("FAIL rand_timing[%0d] lat=%0d ready_bad=%b want lat=%0d", i, lat, rbad, N); end
      checks++; if (bus.p !== e) begin errors++; $display("FAIL rand_p[%0d] got=%0h want=%0h", i, bus.p, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit rbad;
    logic [WIDTH-1:0] x, y;
    logic [2*WIDTH-1:0] e;
    issue(WIDTH'(3423), WIDTH'(434), 1'b0);
    wait_done(lat, rbad);
    x = rand_wide();
    y = rand_wide();
    e = ref_product(x, y, 1'b0);
    issue(x, y, 1'b0);
    wait_done(lat, rbad);
    checks++; if (lat !== N) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", lat, N); end
    checks++; if (bus.p !== e) begin errors++; $display("FAIL b2b_p got=%0h want=%0h", bus.p, e); end
    @(negedge clk);
  endtask

`ifdef MUL_SEQ_SIGNED_EN
  task automatic test_signed();
    int lat; bit rbad;
    logic [WIDTH-1:0] x, y;
    logic [2*WIDTH-1:0] e;
    x = -WIDTH'(3423);
    e = -(2*WIDTH)'(1485582);
    issue(x, WIDTH'(434), 1'b1);
    wait_done(lat, rbad);
    checks++; if (lat !== N) begin errors++; $display("FAIL signed_latency got=%0d want=%0d", lat, N); end
    checks++; if (bus.p !== e) begin errors++; $display("FAIL signed_p got=%0h want=%0h", bus.p, e); end
    @(negedge clk);
    e = ref_product(x, WIDTH'(434), 1'b0);
    issue(x, WIDTH'(434), 1'b0);
    wait_done(lat, rbad);
    checks++; if (bus.p !== e) begin errors++; $display("FAIL unsigned_same_bits got=%0h want=%0h", bus.p, e); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      x = rand_wide();
      y = rand_wide();
      if (i == 0) begin x = '0; x[WIDTH-1] = 1'b1; end
      e = ref_product(x, y, 1'b1);
      issue(x, y, 1'b1);
      wait_done(lat, rbad);
      checks++; if (bus.p !== e) begin errors++; $display("FAIL signed_rand[%0d] got=%0h want=%0h", i, bus.p, e); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    set_sgn(1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_busy_start();
    test_mid_reset();
    test_random();
    test_back_to_back();
`ifdef MUL_SEQ_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised, iterative multi-cycle multiplier; successor to the combinational `mul1024`. Computes the full-width product of two `WIDTH`-bit operands by consuming `DIGIT` bits of the multiplier per clock, with a start/done handshake. It serves datapaths where a single-cycle 1024×1024 array is too large or too slow. Area and latency trade off through `DIGIT`.

## Interface
- `WIDTH`, 1024, operand width in bits.
- `DIGIT`, 32, multiplier bits consumed per cycle. `WIDTH % DIGIT` must be 0; any other value is an elaboration error.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a multiply; sampled only when `ready`=1.
- `a` input `WIDTH`: multiplicand, captured at the accepting edge.
- `b` input `WIDTH`: multiplier, captured at the accepting edge.
- `sgn` input 1: signed-mode select, captured with `start`. Present only with `MUL_SEQ_SIGNED_EN`.
- `ready` output 1: block is idle and accepts `start`.
- `done` output 1: single-cycle pulse; `p` is valid from this cycle onward.
- `p` output `2*WIDTH`: product, registered and held until the next accepted `start` completes.

## Operation
- N = `WIDTH/DIGIT` iterations.
- States are defined in the package:
  - IDLE: `ready`=1. When `start`=1, capture `a`, `b` (and `sgn`), clear the accumulator and counter, then go to RUN.
  - RUN: `ready`=0. For counter `k` from 0 to N-1, each cycle:
    - add `a` × digit `k` of `b` into the upper `WIDTH+DIGIT` bits of the `2*WIDTH+DIGIT`-bit accumulator;
    - shift the accumulator right by `DIGIT`.
  - After iteration N-1, write the low `2*WIDTH` bits to `p`, pulse `done`, and return to IDLE.
- The product is exact with no truncation: `p` = `a`×`b` modulo 2^(2·`WIDTH`), which equals the exact product for unsigned operands.
- A `start` arriving while `ready`=0 is ignored. It is neither queued nor allowed to corrupt the operation in flight.
- Input changes after the accepting edge have no effect.
- `p` changes only on the edge that raises `done`, or on reset.
- Reset at any time, including mid-RUN, aborts the operation:
  - next cycle: IDLE, `ready`=1, `done`=0, `p`=0;
  - the counter and accumulator are cleared.
- Operands of zero still take the full N iterations. There is no early termination.

## Timing
- Reset values: `ready`=1, `done`=0, `p`=0, state IDLE.
- `start` is accepted at edge E0. `ready` is low for the cycles following E0 through EN.
- `p` and `done` are updated at edge EN. Latency is N cycles from the accepting edge.
- `ready` returns to 1 in the same cycle `done` is high. A new `start` can be accepted at edge EN+1.
- Throughput: one product per N+1 cycles.
- `done` is high for exactly one cycle per accepted `start`.
- `DIGIT`=`WIDTH` gives N=1, a 1-cycle latency.

## Configuration
- `MUL_SEQ_SIGNED_EN` defined:
  - adds the `sgn` port;
  - when `sgn`=1 at acceptance, `a` and `b` are two's complement;
  - magnitudes are formed at capture, multiplied unsigned, and the result is negated at the final edge if the operand signs differ;
  - latency is unchanged;
  - `sgn`=0 behaves identically to the build without the macro.
- Macro undefined: unsigned only, no `sgn` port, no sign logic.

## Structure
- Package `mul_pkg` holds:
  - the state enum `mul_state_t` {IDLE, RUN};
  - the localparam helper computing N and the counter width `$clog2(N+1)`.
- Sub-module `mul_seq_pe` performs the `WIDTH`×`DIGIT` partial product plus accumulator-slice add. It is purely combinational and instantiated once.
- The top level holds the FSM, counter, operand registers, accumulator and output register.

## Test plan
- Reset, then `a`=3423, `b`=434, `start` for 1 cycle → exactly N cycles later `done`=1 and `p`=1485582; `ready` low in between.
- `a`=`b`=2^`WIDTH`-1 → `p`=2^(2·`WIDTH`) − 2^(`WIDTH`+1) + 1.
- `a`=0, `b`=434 → `p`=0 after the full N cycles; `done` pulses once.
- While busy on 3423×434, pulse `start` with `a`=5, `b`=7 → `p`=1485582, with no second `done` and no later `p`=35.
- Assert `rst` for 1 cycle at iteration N/2 → next cycle `ready`=1, `done`=0, `p`=0. A following 5×7 then gives `p`=35 after N cycles.
- With `MUL_SEQ_SIGNED_EN`, `sgn`=1, `a`=−3423 (two's complement), `b`=434 → `p`=−1485582 in 2·`WIDTH`-bit two's complement. With `sgn`=0 and the same bit patterns, `p` is the unsigned product.
